t09_response_checker: RTL

T09_RESPONSE_CHECKER -- requirements
Module: t09_response_checker

---
 rtl/t09_response_checker_pkg.sv | 13 +
 rtl/t09_response_checker.sv | 105 ++++++++++
 2 files changed

// File: rtl/t09_response_checker_pkg.sv
// Shared constants for the response checker: FSM encoding and the
// sizes of the pattern index and ones counter.
package t09_checker_pkg;

  localparam int NUM_PAT = 32;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/t09_response_checker.sv
// Captures 32 serial DUT responses, compares them with a golden vector and
// reports pass/fail, the ones count and the index of the first mismatch.
module t09_response_checker
  import t09_checker_pkg::*;
#(
  parameter logic [NUM_PAT-1:0] EXP_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               z_valid,
  input  logic               z,
  output logic [IDX_W-1:0]   pat_idx,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_PAT-1:0] capture,
  output logic [CNT_W-1:0]   ones_cnt,
  output logic               err,
  output logic [IDX_W-1:0]   err_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

  logic [1:0]         state_q,    state_d;
  logic [IDX_W-1:0]   pat_idx_q,  pat_idx_d;
  logic [NUM_PAT-1:0] capture_q,  capture_d;
  logic [CNT_W-1:0]   ones_cnt_q, ones_cnt_d;
  logic               err_q,      err_d;
  logic [IDX_W-1:0]   err_idx_q,  err_idx_d;
  logic               pass_q,     pass_d;

  always_comb begin
    state_d    = state_q;
    pat_idx_d  = pat_idx_q;
    capture_d  = capture_q;
    ones_cnt_d = ones_cnt_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          pat_idx_d  = '0;
          capture_d  = '0;
          ones_cnt_d = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          pass_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (z_valid) begin
          capture_d[pat_idx_q] = z;
          ones_cnt_d           = ones_cnt_q + {{(CNT_W-1){1'b0}}, z};
          pat_idx_d            = pat_idx_q + 1'b1;
          // Only the first mismatch of a run is recorded.
          if ((z != EXP_VECTOR[pat_idx_q]) && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = pat_idx_q;
          end
          // pass is settled here so it is already valid during the done cycle.
          if (pat_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            pass_d  = ~err_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pat_idx_q  <= '0;
      capture_q  <= '0;
      ones_cnt_q <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_idx_q  <= pat_idx_d;
      capture_q  <= capture_d;
      ones_cnt_q <= ones_cnt_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign pat_idx  = pat_idx_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign capture  = capture_q;
  assign ones_cnt = ones_cnt_q;
  assign err      = err_q;
  assign err_idx  = err_idx_q;

endmodule
